// File: rtl/q_episode_sequencer.sv
// q_episode_sequencer: epsilon-greedy step/episode controller for the Q-learning maze datapath
//   clk, rst (async, active-high)  | en: run enable, low freezes everything
//   epsilon: explore threshold     | greedy_action/greedy_valid: agent reply to q_req
//   next_state/reward: selector and reward path for (current_state, next_action)
//   q_req, current_state, next_action: step request and registered action
//   q_update, upd_state, upd_reward: one-cycle Q-table update command
//   episode_done, goal_reached, step_count, episode_count: episode bookkeeping
module q_episode_sequencer #(
  parameter int STATE_W     = 6,
  parameter int ACTION_W    = 4,
  parameter int REWARD_W    = 16,
  parameter int EPS_W       = 8,
  parameter int MAX_STEPS   = 64,
  parameter int START_STATE = 0,
  parameter int GOAL_STATE  = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [EPS_W-1:0]    epsilon,
  input  logic [ACTION_W-1:0] greedy_action,
  input  logic                greedy_valid,
  input  logic [STATE_W-1:0]  next_state,
  input  logic [REWARD_W-1:0] reward,
  output logic                q_req,
  output logic [STATE_W-1:0]  current_state,
  output logic [ACTION_W-1:0] next_action,
  output logic                q_update,
  output logic [STATE_W-1:0]  upd_state,
  output logic [REWARD_W-1:0] upd_reward,
  output logic                episode_done,
  output logic                goal_reached,
  output logic [15:0]         step_count,
  output logic [15:0]         episode_count
);
  localparam logic [STATE_W-1:0] START = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] GOAL  = STATE_W'(GOAL_STATE);
  localparam logic [15:0]        MAX   = 16'(MAX_STEPS);
  typedef enum logic [2:0] {IDLE, SELECT, MOVE, LATCH, UPDATE, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] lfsr;
  logic [ACTION_W-1:0] action_sel;
  logic accept, explore, greedy_ok;
  assign accept    = state == SELECT && greedy_valid;
  assign explore   = lfsr[7:0] < epsilon;
  assign greedy_ok = greedy_action != '0 && (greedy_action & (greedy_action - ACTION_W'(1))) == '0;
  // a malformed greedy reply falls back to North so the selector always sees a one-hot action
  assign action_sel = explore ? ACTION_W'(1) << lfsr[9:8] : greedy_ok ? greedy_action : ACTION_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else if (en) state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SELECT;
      SELECT:  state_nxt = greedy_valid ? MOVE : SELECT;
      MOVE:    state_nxt = LATCH;
      LATCH:   state_nxt = UPDATE;
      UPDATE:  state_nxt = CHECK;
      CHECK:   state_nxt = (current_state == GOAL || step_count == MAX) ? DONE : SELECT;
      DONE:    state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    q_req        = state == SELECT;
    q_update     = en && state == UPDATE;
    episode_done = en && state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr          <= 16'hACE1;
      current_state <= START;
      next_action   <= ACTION_W'(1);
      upd_state     <= '0;
      upd_reward    <= '0;
      goal_reached  <= 1'b0;
      step_count    <= '0;
      episode_count <= '0;
    end else if (en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (accept) next_action <= action_sel;
      if (state == LATCH) begin
        upd_state  <= next_state;
        upd_reward <= reward;
        step_count <= step_count + 16'd1;
      end
      if (state == UPDATE) current_state <= upd_state;
      if (state == DONE) begin
        goal_reached  <= current_state == GOAL;
        episode_count <= episode_count + 16'd1;
        step_count    <= '0;
        current_state <= START;
      end
    end
endmodule

// File: tb/tb_q_episode_sequencer.sv
// tb_q_episode_sequencer: randomized bench with a transaction-level reference model
module tb_q_episode_sequencer;
  localparam int MAXS = 64;
  logic clk = 1'b0;
  logic rst, en, greedy_valid;
  logic [7:0] epsilon;
  logic [3:0] greedy_action;
  logic [5:0] next_state;
  logic [15:0] reward;
  logic q_req, q_update, episode_done, goal_reached;
  logic [5:0] current_state, upd_state;
  logic [3:0] next_action;
  logic [15:0] upd_reward, step_count, episode_count;
  int checks = 0, errors = 0;
  int mode, fixed_dly, fixed_g, en_drop_pct, freeze_left;
  bit eps_rand, freeze_req, saw_done;
  int n_en, upd_at, done_at, dly;
  logic [15:0] m_lfsr, e_step, e_ep, p_step, e_upd_r, p_r;
  logic [5:0] e_cur, p_ns, e_upd_s;
  logic [3:0] e_act, p_act;
  bit selecting, acc, e_goal, p_goal, p_term;
  q_episode_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .epsilon(epsilon), .greedy_action(greedy_action),
    .greedy_valid(greedy_valid), .next_state(next_state), .reward(reward), .q_req(q_req),
    .current_state(current_state), .next_action(next_action), .q_update(q_update),
    .upd_state(upd_state), .upd_reward(upd_reward), .episode_done(episode_done),
    .goal_reached(goal_reached), .step_count(step_count), .episode_count(episode_count)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] sel_fn(logic [5:0] s, logic [3:0] a, logic [15:0] st, int m);
    int row, col;
    row = int'(s) / 8;
    col = int'(s) % 8;
    case (m)
      0: return s + 6'd1;
      1: return 6'd5;
      3: return s + 6'd7;
      4: return st == 16'd63 ? 6'd63 : 6'd5;
      default: begin
        if (a == 4'b0001 && row > 0) row--;
        if (a == 4'b0010 && col < 7) col++;
        if (a == 4'b0100 && row < 7) row++;
        if (a == 4'b1000 && col > 0) col--;
        return 6'(row * 8 + col);
      end
    endcase
  endfunction
  function automatic logic [15:0] rew_fn(logic [5:0] s);
    return s == 6'd63 ? 16'd100 : 16'(s) * 16'd3 - 16'd20;
  endfunction
  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  function automatic logic [3:0] pick(logic [15:0] l, logic [7:0] e, logic [3:0] g);
    if (int'(l[7:0]) < int'(e)) return 4'b0001 << l[9:8];
    if (g == 4'd1 || g == 4'd2 || g == 4'd4 || g == 4'd8) return g;
    return 4'b0001;
  endfunction
  function automatic int new_dly();
    return fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
  endfunction
  assign next_state = sel_fn(current_state, next_action, step_count, mode);
  assign reward = rew_fn(next_state);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic reset_model();
    n_en = 0; upd_at = -100; done_at = -100; m_lfsr = 16'hACE1; selecting = 0; dly = 0;
    e_act = 4'b0001; e_cur = 0; e_step = 0; e_ep = 0; e_goal = 0; e_upd_s = 0; e_upd_r = 0; acc = 0;
  endtask
  task automatic drive();
    if (freeze_left > 0) begin en = 0; freeze_left--; end
    else if (freeze_req && n_en == upd_at - 1) begin en = 0; freeze_left = 19; freeze_req = 0; end
    else en = int'($urandom_range(0, 99)) >= en_drop_pct;
    if (eps_rand) epsilon = 8'($urandom);
    if (selecting) begin
      greedy_valid = dly == 0;
      greedy_action = fixed_g >= 0 ? 4'(fixed_g) : 4'($urandom);
      if (!greedy_valid && en) dly--;
    end else begin
      greedy_valid = $urandom_range(0, 7) == 0;
      greedy_action = 4'($urandom);
    end
    acc = en && greedy_valid && selecting;
    if (acc) begin
      p_act = pick(m_lfsr, epsilon, greedy_action);
      p_ns = sel_fn(e_cur, p_act, e_step, mode);
      p_step = e_step + 16'd1;
      p_goal = p_ns == 6'd63;
      p_term = p_goal || int'(p_step) == MAXS;
      p_r = rew_fn(p_ns);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (en && !rst) begin
      n_en++;
      m_lfsr = lfsr_next(m_lfsr);
      if (n_en == 1) begin selecting = 1; dly = new_dly(); end
      if (acc) begin selecting = 0; e_act = p_act; upd_at = n_en + 2; end
      if (n_en == upd_at) begin e_step = p_step; e_upd_s = p_ns; e_upd_r = p_r; end
      if (n_en == upd_at + 1) e_cur = p_ns;
      if (n_en == upd_at + 2) begin
        if (p_term) done_at = n_en;
        else begin selecting = 1; dly = new_dly(); end
      end
      if (n_en == done_at + 1) begin
        e_cur = 0; e_step = 0; e_ep++; e_goal = p_goal; selecting = 1; dly = new_dly();
      end
    end
    @(negedge clk);
    check("q_req", q_req, selecting);
    check("q_update", q_update, en && n_en == upd_at);
    check("episode_done", episode_done, en && n_en == done_at);
    check("next_action", next_action, e_act);
    check("current_state", current_state, e_cur);
    check("step_count", step_count, e_step);
    check("episode_count", episode_count, e_ep);
    check("goal_reached", goal_reached, e_goal);
    check("upd_state", upd_state, e_upd_s);
    check("upd_reward", upd_reward, e_upd_r);
    saw_done = episode_done;
    drive();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic run_until_done(input int limit, input string tag, input int steps, input bit goal, input int ep);
    saw_done = 0;
    for (int i = 0; i < limit && !saw_done; i++) tick();
    check({tag, "_seen"}, saw_done, 1);
    check({tag, "_steps"}, step_count, steps);
    tick();
    check({tag, "_goal"}, goal_reached, goal);
    check({tag, "_ep"}, episode_count, ep);
    check({tag, "_cur"}, current_state, 0);
    check({tag, "_step0"}, step_count, 0);
  endtask
  initial begin
    rst = 1; en = 0; epsilon = 0; greedy_action = 0; greedy_valid = 0;
    mode = 0; fixed_dly = 2; fixed_g = 2; en_drop_pct = 0; eps_rand = 0; freeze_req = 0; freeze_left = 0;
    reset_model();
    @(negedge clk);
    check("rst_q_req", q_req, 0);
    check("rst_cur", current_state, 0);
    check("rst_act", next_action, 4'b0001);
    check("rst_q_update", q_update, 0);
    check("rst_done", episode_done, 0);
    check("rst_goal", goal_reached, 0);
    check("rst_step", step_count, 0);
    check("rst_ep", episode_count, 0);
    check("rst_upd_state", upd_state, 0);
    check("rst_upd_reward", upd_reward, 0);
    rst = 0;
    drive();
    run_until_done(700, "greedy_goal", 63, 1, 1);
    mode = 3; fixed_dly = -1;
    run_until_done(300, "short_goal", 9, 1, 2);
    mode = 1;
    run_until_done(800, "timeout", 64, 0, 3);
    mode = 4;
    run_until_done(800, "goal_and_timeout", 64, 1, 4);
    saw_done = 0;
    for (int i = 0; i < 200 && !saw_done; i++) begin
      tick();
      saw_done = n_en == upd_at;
    end
    check("mid_find_update", saw_done, 1);
    en = 1;
    #1 check("mid_pulse", q_update, 1);
    rst = 1;
    #1 check("mid_q_update", q_update, 0);
    check("mid_cur", current_state, 0);
    check("mid_step", step_count, 0);
    check("mid_ep", episode_count, 0);
    check("mid_act", next_action, 4'b0001);
    check("mid_q_req", q_req, 0);
    @(negedge clk);
    rst = 0;
    reset_model();
    mode = 2; epsilon = 8'd255; fixed_g = 0; en_drop_pct = 10; freeze_req = 1;
    drive();
    run(1500);
    epsilon = 0; fixed_g = -1;
    run(1000);
    eps_rand = 1; en_drop_pct = 20;
    run(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
